satd_sequencer: RTL and testbench
=================================

# satd_sequencer

Sequencer for the SATD (sum of absolute transformed differences) datapath. It accepts one block request at a time through a valid/ready handshake and steps the Hadamard datapath through load, row-transform, column-transform and accumulate stages, driving the shared `stage`/`count` sequencing bus. It accumulates the per-row absolute sums returned by the datapath and presents the block SATD on a valid/ready output. It sits between the motion-estimation block-request logic and the SATD datapath, replacing free-running stage control.

## Interface
- `SUM_W`, 12: width of the per-row absolute sum from the datapath.
- `ACC_W`, `SUM_W+3`: accumulator and result width; holds 8 row sums without overflow.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start_valid` in 1: block request.
- `start_ready` out 1: request accepted when both are high.
- `size8` in 1: block size, 1 = 8x8, 0 = 4x4; sampled at accept.
- `flush` in 1: abort the current block.
- `abs_sum` in `SUM_W`: datapath row absolute sum, valid while `acc_en` is high.
- `stage` out 2: 0 = LOAD, 1 = ROW, 2 = COL, 3 = ACCUM.
- `count` out 3: row index within the stage.
- `load_en`, `row_en`, `col_en`, `acc_en` out 1 each: per-stage datapath enables.
- `busy` out 1: a block is in progress (LOAD through ACCUM).
- `out_valid` out 1: `satd` is valid.
- `out_ready` in 1: consumer accepts `satd`.
- `satd` out `ACC_W`: block result.

## Operation
- FSM states: IDLE, LOAD, ROW, COL, ACCUM, DONE.
- IDLE: `start_ready`=1. On accept:
  - latch `size8`; N = 8 if `size8`, else 4;
  - clear the accumulator;
  - go to LOAD with `count`=0.
- LOAD, ROW, COL, ACCUM:
  - each stage lasts exactly N cycles; `count` runs 0..N-1;
  - on `count`=N-1, move to the next stage with `count`=0;
  - `stage` equals the stage encoding; exactly one enable is high, matching the stage.
- ACCUM: every cycle, acc <= acc + zero-extended `abs_sum`. After the cycle with `count`=N-1, go to DONE.
- DONE:
  - `out_valid`=1 and `satd` is held stable until `out_ready`;
  - on the handshake, go to IDLE;
  - a new request can be accepted at the earliest on the cycle after the handshake.
- `flush` when not in IDLE:
  - next cycle the FSM is in IDLE with `count`=0, all enables 0, `out_valid`=0, and the accumulator cleared;
  - `flush` has priority over every other transition, including the DONE handshake;
  - `flush` in IDLE has no effect.
- `start_valid` outside IDLE is ignored; the request is not queued.
- `size8` changes mid-block are ignored.
- `count` never exceeds N-1; in 4x4 mode bit 2 stays 0.

## Timing
- Reset values:
  - state IDLE, `stage`=0, `count`=0;
  - all enables 0, `busy`=0, `out_valid`=0, `satd`=0, accumulator 0;
  - `start_ready`=1, decoded from IDLE.
- Reset mid-block behaves like `flush`.
- All outputs except `start_ready` are registered.
- Accept at edge E: LOAD `count`=0 is visible after E. `out_valid` rises 4N cycles after E: 32 for 8x8, 16 for 4x4.
- With `out_ready` held high, DONE lasts exactly 1 cycle.
- Throughput: one block every 4N+2 cycles at best.

## Configuration
- `SATD_NORM_EN`:
  - defined: `satd` = (acc + 2) >> 2 for 8x8 and (acc + 1) >> 1 for 4x4, zero-extended to `ACC_W`;
  - undefined: `satd` = raw acc.
- Only the DONE output path changes; sequencing and latency are identical in both builds.

## Structure
- Shared package `satd_pkg` holds:
  - the stage encodings (`STG_LOAD`=0, `STG_ROW`=1, `STG_COL`=2, `STG_ACC`=3);
  - the FSM state encoding;
  - the row counts (`ROWS_8X8`=8, `ROWS_4X4`=4).
- One sub-module, `satd_stage_counter`:
  - a 3-bit counter with clear, enable and a `last` flag at N-1;
  - it drives `count` and the stage-advance condition.

## Test plan
- Reset, then 8x8 request with `abs_sum`=100 on every ACCUM cycle -> `out_valid` 32 cycles after accept; `satd`=800 (200 with `SATD_NORM_EN`).
- 4x4 request with `abs_sum` sequence 1, 2, 3, 4 -> `stage` walks 0, 1, 2, 3 with `count` 0..3 each; `satd`=10 (5 with `SATD_NORM_EN`); `count[2]` always 0.
- Hold `out_ready`=0 for 5 cycles in DONE -> `satd` and `out_valid` stable for those 5 cycles; `start_valid` pulses are ignored; IDLE on the cycle after `out_ready`.
- Assert `flush` at ROW `count`=3 -> next cycle IDLE, `count`=0, `busy`=0; a following request gives a correct fresh result.
- Drive `reset`=0 during ACCUM -> all reset values next cycle.
- Toggle `size8` mid-block and hold `abs_sum`=`2^SUM_W - 1` for 8x8 -> sequencing is unchanged; `satd`=32760 with no overflow.

Source files
------------

// File: rtl/satd_pkg.sv
// satd_pkg: shared encodings for the SATD sequencer.
//   - stage bus encodings driven on `stage`
//   - sequencer FSM state encoding
//   - row counts for the two block sizes and a helper giving the last row index
package satd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROW   = 3'd2,
        ST_COL   = 3'd3,
        ST_ACCUM = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] STG_LOAD = 2'd0;
    localparam logic [1:0] STG_ROW  = 2'd1;
    localparam logic [1:0] STG_COL  = 2'd2;
    localparam logic [1:0] STG_ACC  = 2'd3;

    localparam int ROWS_8X8 = 8;
    localparam int ROWS_4X4 = 4;

    // Index of the final row of a stage for the given block size.
    function automatic logic [2:0] last_row(input logic size8);
        return size8 ? 3'(ROWS_8X8 - 1) : 3'(ROWS_4X4 - 1);
    endfunction

endpackage

// File: rtl/satd_stage_counter.sv
// satd_stage_counter: 3-bit row counter for the SATD sequencer.
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   clr            - force count to 0 (priority over en)
//   en             - advance; wraps to 0 after last_idx
//   last_idx       - final row index (N-1)
//   count          - current row index (registered)
//   last           - count equals last_idx; marks the stage-advance cycle
module satd_stage_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] last_idx,
    output logic [2:0] count,
    output logic       last
);

    logic [2:0] count_q, count_d;

    assign last  = (count_q == last_idx);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = 3'd0;
        else if (en)
            count_d = last ? 3'd0 : count_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= 3'd0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/satd_sequencer.sv
// satd_sequencer: steps the Hadamard SATD datapath through LOAD, ROW, COL and
// ACCUM (N cycles each, N = 8 or 4), accumulates the per-row absolute sums and
// presents the block SATD on a valid/ready output.
// Ports:
//   clk, reset                - clock, synchronous active-low reset
//   start_valid/start_ready   - block request handshake; size8 sampled at accept
//   flush                     - abort the block in progress (no effect in IDLE)
//   abs_sum                   - datapath row sum, sampled while acc_en is high
//   stage, count              - sequencing bus to the datapath
//   load_en/row_en/col_en/acc_en - one-hot stage enables
//   busy                      - LOAD through ACCUM
//   out_valid/out_ready, satd - result handshake
// Build option: SATD_NORM_EN defined -> satd is the rounded, size-normalised
// accumulator; undefined -> raw accumulator.
module satd_sequencer
    import satd_pkg::*;
#(
    parameter int SUM_W = 12,
    parameter int ACC_W = SUM_W + 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             size8,
    input  logic             flush,
    input  logic [SUM_W-1:0] abs_sum,
    output logic [1:0]       stage,
    output logic [2:0]       count,
    output logic             load_en,
    output logic             row_en,
    output logic             col_en,
    output logic             acc_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] satd
);

    state_e           state_q, state_d;
    logic             size8_q, size8_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [ACC_W-1:0] satd_q, satd_d, satd_next;
    logic [1:0]       stage_q, stage_d;
    logic             load_en_q, load_en_d, row_en_q, row_en_d;
    logic             col_en_q, col_en_d, acc_en_q, acc_en_d;
    logic             busy_q, busy_d, out_valid_q, out_valid_d;
    logic             cnt_clr, cnt_en, cnt_last;

    satd_stage_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .last_idx (last_row(size8_q)),
        .count    (count),
        .last     (cnt_last)
    );

    assign start_ready = (state_q == ST_IDLE);
    assign acc_sum     = acc_q + {{(ACC_W-SUM_W){1'b0}}, abs_sum};

    // Result value captured on the final ACCUM cycle, including that cycle's row.
`ifdef SATD_NORM_EN
    logic [ACC_W:0] acc_rnd;
    always_comb begin
        acc_rnd   = {1'b0, acc_sum} + (size8_q ? (ACC_W+1)'(2) : (ACC_W+1)'(1));
        satd_next = size8_q ? {1'b0, acc_rnd[ACC_W:2]} : acc_rnd[ACC_W:1];
    end
`else
    assign satd_next = acc_sum;
`endif

    always_comb begin
        state_d = state_q;
        size8_d = size8_q;
        acc_d   = acc_q;
        satd_d  = satd_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d = ST_LOAD;
                    size8_d = size8;
                    acc_d   = '0;
                end
            end
            ST_LOAD: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = ST_ROW;
            end
            ST_ROW: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = ST_COL;
            end
            ST_COL: begin
                cnt_en = 1'b1;
                if (cnt_last) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                cnt_en = 1'b1;
                acc_d  = acc_sum;
                if (cnt_last) begin
                    state_d = ST_DONE;
                    satd_d  = satd_next;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats every other transition, including the DONE handshake.
        if (flush && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end

        // Registered outputs are decoded from the next state so they line up
        // with the state they describe.
        stage_d     = STG_LOAD;
        load_en_d   = 1'b0;
        row_en_d    = 1'b0;
        col_en_d    = 1'b0;
        acc_en_d    = 1'b0;
        busy_d      = 1'b0;
        out_valid_d = (state_d == ST_DONE);
        case (state_d)
            ST_LOAD:  begin stage_d = STG_LOAD; load_en_d = 1'b1; busy_d = 1'b1; end
            ST_ROW:   begin stage_d = STG_ROW;  row_en_d  = 1'b1; busy_d = 1'b1; end
            ST_COL:   begin stage_d = STG_COL;  col_en_d  = 1'b1; busy_d = 1'b1; end
            ST_ACCUM: begin stage_d = STG_ACC;  acc_en_d  = 1'b1; busy_d = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            size8_q     <= 1'b0;
            acc_q       <= '0;
            satd_q      <= '0;
            stage_q     <= STG_LOAD;
            load_en_q   <= 1'b0;
            row_en_q    <= 1'b0;
            col_en_q    <= 1'b0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            size8_q     <= size8_d;
            acc_q       <= acc_d;
            satd_q      <= satd_d;
            stage_q     <= stage_d;
            load_en_q   <= load_en_d;
            row_en_q    <= row_en_d;
            col_en_q    <= col_en_d;
            acc_en_q    <= acc_en_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign stage     = stage_q;
    assign load_en   = load_en_q;
    assign row_en    = row_en_q;
    assign col_en    = col_en_q;
    assign acc_en    = acc_en_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign satd      = satd_q;

endmodule

// File: tb/tb_satd_sequencer.sv
// Bench for satd_sequencer: randomized blocks, expected SATD pushed into a
// scoreboard queue at request time, popped by an independent output monitor.
module tb_satd_sequencer;

    localparam int SUM_W = 12;
    localparam int ACC_W = SUM_W + 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start_valid = 1'b0;
    logic             size8 = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic [SUM_W-1:0] abs_sum = '0;
    logic             start_ready, load_en, row_en, col_en, acc_en, busy, out_valid;
    logic [1:0]       stage;
    logic [2:0]       count;
    logic [ACC_W-1:0] satd;

    satd_sequencer #(.SUM_W(SUM_W), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .size8       (size8),
        .flush       (flush),
        .abs_sum     (abs_sum),
        .stage       (stage),
        .count       (count),
        .load_en     (load_en),
        .row_en      (row_en),
        .col_en      (col_en),
        .acc_en      (acc_en),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .satd        (satd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [ACC_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Block SATD from the row sums: plain sum, optionally rounded and divided
    // by 4 (8x8) or 2 (4x4).
    function automatic int ref_satd(input bit s8, input int vals[8], input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += vals[i];
`ifdef SATD_NORM_EN
        s = s8 ? (s + 2) / 4 : (s + 1) / 2;
`endif
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_enables"}, {load_en, row_en, col_en, acc_en}, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
    endtask

    // mode: 0 = all 100, 1 = ramp 1..N, 2 = all max, 3 = random.
    // abort_j: offset after accept at which flush/reset is applied (-1 none);
    // abort_j == 4N means flush in DONE together with out_ready.
    task automatic run_block(input bit s8, input int mode, input int hold,
                             input int abort_j, input bit abort_rst, input bit toggle);
        int n;
        int vals[8];
        n = s8 ? 8 : 4;
        for (int i = 0; i < 8; i++)
            vals[i] = (mode == 0) ? 100 : (mode == 1) ? i + 1 :
                      (mode == 2) ? (1 << SUM_W) - 1 : int'($urandom_range(0, (1 << SUM_W) - 1));
        start_valid = 1'b1;
        size8 = s8;
        chk("start_ready_before_accept", start_ready, 1);
        if (abort_j < 0 || abort_j == 4 * n)
            exp_q.push_back(ACC_W'(ref_satd(s8, vals, n)));
        step();
        for (int j = 0; j < 4 * n; j++) begin
            chk("stage", stage, j / n);
            chk("count", count, j % n);
            chk("enables", {load_en, row_en, col_en, acc_en}, 4'b1000 >> (j / n));
            chk("busy", busy, 1);
            chk("out_valid_early", out_valid, 0);
            chk("start_ready_busy", start_ready, 0);
            start_valid = 1'($urandom_range(0, 1));
            size8 = toggle ? ~size8 : 1'($urandom_range(0, 1));
            abs_sum = (j >= 3 * n) ? SUM_W'(vals[j - 3 * n]) : SUM_W'($urandom);
            if (j == abort_j) begin
                if (abort_rst) reset = 1'b0; else flush = 1'b1;
                step();
                chk_idle(abort_rst ? "reset_mid" : "flush_mid");
                if (abort_rst) begin
                    chk("reset_mid_stage", stage, 0);
                    chk("reset_mid_satd", satd, 0);
                end
                reset = 1'b1;
                flush = 1'b0;
                start_valid = 1'b0;
                return;
            end
            step();
        end
        start_valid = 1'b0;
        abs_sum = SUM_W'($urandom);
        chk("out_valid_latency", out_valid, 1);
        chk("busy_done", busy, 0);
        if (abort_j == 4 * n) begin
            out_ready = 1'b1;
            flush = 1'b1;
            step();
            chk_idle("flush_done");
            flush = 1'b0;
            out_ready = 1'b0;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start_valid = 1'($urandom_range(0, 1));
            step();
            chk("out_valid_hold", out_valid, 1);
            chk("start_ready_hold", start_ready, 0);
        end
        start_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_idle("after_handshake");
    endtask

    // Output monitor: satd must match the expected head every cycle it is
    // valid; the entry retires on handshake or abort.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                if (exp_q.size() == 0)
                    chk("unexpected_out_valid", 1, 0);
                else begin
                    chk("satd", satd, exp_q[0]);
                    if (out_ready || flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        step();
        step();
        chk_idle("reset");
        chk("reset_stage", stage, 0);
        chk("reset_satd", satd, 0);
        reset = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_idle("flush_in_idle");

        run_block(1'b1, 0, 0, -1, 1'b0, 1'b0);   // 8x8, all 100
        run_block(1'b0, 1, 0, -1, 1'b0, 1'b0);   // 4x4, 1..4
        run_block(1'b1, 3, 5, -1, 1'b0, 1'b0);   // held DONE, ignored requests
        run_block(1'b1, 3, 0, 8 + 3, 1'b0, 1'b0); // flush at ROW count 3
        run_block(1'b1, 3, 0, -1, 1'b0, 1'b0);   // fresh block after flush
        run_block(1'b0, 3, 0, 12 + 2, 1'b1, 1'b0); // reset during ACCUM
        run_block(1'b0, 3, 1, -1, 1'b0, 1'b0);
        run_block(1'b1, 2, 0, -1, 1'b0, 1'b1);   // max sums, size8 toggling
        run_block(1'b0, 3, 0, 16, 1'b0, 1'b0);   // flush wins over DONE handshake
        run_block(1'b0, 3, 2, -1, 1'b0, 1'b0);
        for (int b = 0; b < 20; b++)
            run_block(1'($urandom_range(0, 1)), 3, int'($urandom_range(0, 3)), -1, 1'b0, 1'b0);

        repeat (5) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
